// File: rtl/jk_bank_ctrl_if.sv
// Command and bank-bus bundle for jk_bank_ctrl: valid/ready command channel,
// the J/K drive vectors toward the flip-flop bank, and the bank's Q readback.
interface jk_bank_ctrl_if #(
    parameter int N  = 4,
    parameter int CW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic          serial_in;
    logic [N-1:0]  q_in;
    logic [N-1:0]  j_out;
    logic [N-1:0]  k_out;
    logic          busy;
    logic          done;

    // Host side: issues commands and presents the bank's Q.
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, serial_in, q_in,
        input  cmd_ready, j_out, k_out, busy, done
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, serial_in, q_in,
        output cmd_ready, j_out, k_out, busy, done
    );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencing controller for a bank of N external JK flip-flops.
// Each step drives J/K for one cycle (DRIVE) and then releases them for one
// cycle (SETTLE) so the bank's new Q is stable on q_in before the next step's
// vectors are derived from it.
module jk_bank_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    jk_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_INCR   = 3'd4;
    localparam logic [2:0] OP_DECR   = 3'd5;
    localparam logic [2:0] OP_SHL    = 3'd6;

    state_t        state;
    logic [CW-1:0] steps;
    logic [2:0]    op_l;
    logic [N-1:0]  data_l;

    logic          ready;
    logic          accept;
    logic          counted;
    logic          single;
    logic          instant;
    logic [CW-1:0] init_steps;
    logic [2:0]    vec_op;
    logic [N-1:0]  vec_data;
    logic [N-1:0]  vec_j;
    logic [N-1:0]  vec_k;

    // J/K vectors for one step, packed as {J, K}. Only toggle-type ops ever
    // produce J=K=1 on a bit.
    function automatic logic [2*N-1:0] step_vec(input logic [2:0] op,
                                                input logic [N-1:0] data,
                                                input logic [N-1:0] q,
                                                input logic sin);
        logic [N-1:0]   t;
        logic [N-1:0]   d;
        logic [2*N-1:0] r;
        t = '0;
        d = '0;
        r = '0;
        case (op)
            OP_CLEAR:  r = {{N{1'b0}}, {N{1'b1}}};
            OP_LOAD:   r = {data, ~data};
            OP_TOGGLE: r = {data, data};
            OP_INCR: begin
                t[0] = 1'b1;
                for (int i = 1; i < N; i++) t[i] = t[i-1] & q[i-1];
                r = {t, t};
            end
            OP_DECR: begin
                t[0] = 1'b1;
                for (int i = 1; i < N; i++) t[i] = t[i-1] & ~q[i-1];
                r = {t, t};
            end
            OP_SHL: begin
                d = {q[N-2:0], sin};
                r = {d, ~d};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign ready         = (state == IDLE) & ~rst;
    assign bus.cmd_ready = ready;
    assign accept        = bus.cmd_valid & ready;

    assign counted    = (bus.cmd_op >= OP_TOGGLE) && (bus.cmd_op <= OP_SHL);
    assign single     = (bus.cmd_op == OP_CLEAR) || (bus.cmd_op == OP_LOAD);
    assign instant    = !(single || counted) || (counted && (bus.cmd_count == '0));
    assign init_steps = single ? CW'(1) : bus.cmd_count;

    // In IDLE the command is being accepted this edge, so its fields come
    // straight from the bus; afterwards the latched copy is used.
    assign vec_op   = (state == IDLE) ? bus.cmd_op   : op_l;
    assign vec_data = (state == IDLE) ? bus.cmd_data : data_l;
    assign {vec_j, vec_k} = step_vec(vec_op, vec_data, bus.q_in, bus.serial_in);

    // Command latch; purely data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_l   <= bus.cmd_op;
            data_l <= bus.cmd_data;
        end
    end

    // Step sequencer with registered J/K, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            steps     <= '0;
            bus.j_out <= '0;
            bus.k_out <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.busy <= 1'b1;
                        steps    <= init_steps;
                        if (instant) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state     <= DRIVE;
                            bus.j_out <= vec_j;
                            bus.k_out <= vec_k;
                        end
                    end
                end
                DRIVE: begin
                    state     <= SETTLE;
                    bus.j_out <= '0;
                    bus.k_out <= '0;
                end
                SETTLE: begin
                    steps <= steps - CW'(1);
                    if (steps > CW'(1)) begin
                        state     <= DRIVE;
                        bus.j_out <= vec_j;
                        bus.k_out <= vec_k;
                    end else begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: a behavioural JK bank closes the loop, an
// arithmetic model predicts bank contents and per-step J/K vectors, and a
// negedge process compares every control output each cycle.
module tb_jk_bank_ctrl;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam logic [N-1:0] ONES = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jk_bank_ctrl_if #(.N(N), .CW(CW)) bus ();

    jk_bank_ctrl #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // External JK bank: set, reset, toggle or hold per bit.
    logic [N-1:0] bank = '0;
    assign bus.q_in = bank;
    always @(posedge clk) bank <= (bus.j_out & ~bank) | (~bus.k_out & bank);

    int checks = 0;
    int errors = 0;

    logic         chk_en = 1'b0;
    logic         e_ready, e_busy, e_done;
    logic [N-1:0] e_j, e_k;
    logic [N-1:0] mq;
    logic [N-1:0] drv_j [16];
    logic [N-1:0] drv_k [16];
    logic [N-1:0] step_q [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_exp(input logic r, input logic b, input logic d,
                           input logic [N-1:0] j, input logic [N-1:0] k);
        e_ready = r; e_busy = b; e_done = d; e_j = j; e_k = k;
    endtask

    // Bank contents after one step, from the operation's arithmetic meaning.
    function automatic logic [N-1:0] model_next(input logic [2:0] op, input logic [N-1:0] data,
                                                input logic [N-1:0] q, input logic s);
        case (op)
            3'd1: return '0;
            3'd2: return data;
            3'd3: return q ^ data;
            3'd4: return q + 1'b1;
            3'd5: return q - 1'b1;
            3'd6: return (q << 1) | N'(s);
            default: return q;
        endcase
    endfunction

    // Expected {J, K}: toggle ops toggle exactly the bits that change,
    // set/reset ops force the target value.
    function automatic logic [2*N-1:0] model_jk(input logic [2:0] op, input logic [N-1:0] data,
                                                input logic [N-1:0] q, input logic s);
        logic [N-1:0] t;
        t = model_next(op, data, q, s);
        case (op)
            3'd1, 3'd2, 3'd6: return {t, ~t};
            3'd3, 3'd4, 3'd5: return {q ^ t, q ^ t};
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", bus.cmd_ready, e_ready);
            check("busy", bus.busy, e_busy);
            check("done", bus.done, e_done);
            check("j_out", bus.j_out, e_j);
            check("k_out", bus.k_out, e_k);
        end
    end

    // Issue one command from an idle cycle (called #1 after a rising edge) and
    // walk the expected cycle schedule. abort_step >= 0 asserts rst in that
    // step's DRIVE cycle.
    task automatic do_cmd(input logic [2:0] op, input logic [N-1:0] data, input logic [CW-1:0] cnt,
                          input logic [31:0] sb, input bit hold, input int abort_step);
        int steps;
        logic [2*N-1:0] jk;
        if (op == 3'd1 || op == 3'd2) steps = 1;
        else if (op >= 3'd3 && op <= 3'd6) steps = int'(cnt);
        else steps = 0;

        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
        bus.cmd_count = cnt;  bus.serial_in = sb[0];
        set_exp(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        bus.cmd_valid = hold ? 1'b1 : 1'($urandom);
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = N'($urandom);
        bus.cmd_count = CW'($urandom);

        for (int k = 0; k < steps; k++) begin
            jk = model_jk(op, data, mq, sb[k]);
            set_exp(1'b0, 1'b1, 1'b0, jk[2*N-1:N], jk[N-1:0]);
            if (k < 16) begin
                drv_j[k] = bus.j_out;
                drv_k[k] = bus.k_out;
            end
            if (k == abort_step) begin
                #1; chk_en = 1'b0; rst = 1'b1; #1;
                check("rst_j_now", bus.j_out, 0);
                check("rst_k_now", bus.k_out, 0);
                check("rst_busy_now", bus.busy, 0);
                check("rst_done_now", bus.done, 0);
                check("rst_ready_low", bus.cmd_ready, 0);
                bus.cmd_valid = 1'b0;
                @(posedge clk); #1;
                check("rst_bank_hold", bank, mq);
                rst = 1'b0; #1;
                check("rst_ready_back", bus.cmd_ready, 1);
                set_exp(1'b1, 1'b0, 1'b0, '0, '0);
                chk_en = 1'b1;
                return;
            end
            @(posedge clk); #1;
            mq = model_next(op, data, mq, sb[k]);
            bus.serial_in = sb[k+1];
            set_exp(1'b0, 1'b1, 1'b0, '0, '0);
            check("bank_step", bank, mq);
            if (k < 16) step_q[k] = bank;
            @(posedge clk); #1;
        end
        set_exp(1'b0, 1'b1, 1'b1, '0, '0);
        bus.cmd_valid = hold;
        @(posedge clk); #1;
        set_exp(1'b1, 1'b0, 1'b0, '0, '0);
        check("bank_end", bank, mq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bit prev_hold;
        bit h;
        int gap;
        logic [2:0] rop;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0;
        bus.cmd_count = '0;   bus.serial_in = 1'b0;
        mq = '0;
        set_exp(1'b1, 1'b0, 1'b0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", bus.cmd_ready, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_j", bus.j_out, 0);
        check("reset_k", bus.k_out, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_cmd(3'd1, 4'b0101, 8'd3, 32'd0, 1'b0, -1);
        check("clear_j", drv_j[0], 4'b0000);
        check("clear_k", drv_k[0], 4'b1111);
        check("clear_q", bank, 4'b0000);

        do_cmd(3'd2, 4'b1010, 8'd0, 32'd0, 1'b0, -1);
        check("load_q", bank, 4'b1010);
        do_cmd(3'd4, 4'b0000, 8'd7, 32'd0, 1'b0, -1);
        check("incr7_q", bank, 4'b0001);

        do_cmd(3'd2, 4'b1111, 8'd0, 32'd0, 1'b0, -1);
        do_cmd(3'd4, 4'b0000, 8'd1, 32'd0, 1'b0, -1);
        check("incr_wrap_q", bank, 4'b0000);
        do_cmd(3'd5, 4'b0000, 8'd1, 32'd0, 1'b0, -1);
        check("decr_wrap_q", bank, 4'b1111);

        do_cmd(3'd2, 4'b1001, 8'd0, 32'd0, 1'b0, -1);
        do_cmd(3'd3, 4'b0110, 8'd2, 32'd0, 1'b0, -1);
        check("toggle_mid_q", step_q[0], 4'b1111);
        check("toggle_q", bank, 4'b1001);

        do_cmd(3'd1, 4'b0000, 8'd0, 32'd0, 1'b0, -1);
        do_cmd(3'd6, 4'b0000, 8'd4, 32'b1101, 1'b0, -1);
        check("shl_q", bank, 4'b1011);
        for (int i = 0; i < 4; i++) check("shl_jk_disjoint", drv_j[i] & drv_k[i], 0);

        do_cmd(3'd4, 4'b0000, 8'd3, 32'd0, 1'b1, -1);
        do_cmd(3'd5, 4'b0000, 8'd1, 32'd0, 1'b0, -1);
        check("hold_q", bank, 4'b1101);

        do_cmd(3'd0, 4'b1111, 8'd5, 32'd0, 1'b0, -1);
        do_cmd(3'd4, 4'b1111, 8'd0, 32'd0, 1'b0, -1);
        do_cmd(3'd7, 4'b1111, 8'd2, 32'd0, 1'b0, -1);
        check("nop_q", bank, 4'b1101);

        do_cmd(3'd2, 4'b0011, 8'd0, 32'd0, 1'b0, -1);
        do_cmd(3'd4, 4'b0000, 8'd5, 32'd0, 1'b0, 2);
        check("rst_mid_q", bank, 4'b0101);

        prev_hold = 1'b0;
        for (int n = 0; n < 60; n++) begin
            gap = prev_hold ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op = 3'($urandom);
                set_exp(1'b1, 1'b0, 1'b0, '0, '0);
                @(posedge clk); #1;
            end
            rop = 3'($urandom);
            h = ($urandom_range(0, 3) == 0);
            do_cmd(rop, N'($urandom), CW'($urandom_range(0, 6)), $urandom, h, -1);
            prev_hold = h;
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
